// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative AES-128 inverse key expander, streams round keys 10 down to 0.
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         busy
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0] round_q, round_d;
    logic rdy_q;
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rot;
    logic [7:0] rcon;
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    // Multiplicative inverse as a^254 followed by the forward affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction
    assign {w0, w1, w2, w3} = key_q;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};
    assign rcon = round_q <= 4'd8 ? 8'h01 << (round_q - 4'd1) : round_q == 4'd9 ? 8'h1b : 8'h36;
    assign p0 = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                   ^ {rcon, 24'h0};
    always_comb begin
        state_d = state_q;
        key_d = key_q;
        round_d = round_q;
        if (state_q == IDLE) begin
            if (in_valid && rdy_q) begin
                key_d = key_in;
                round_d = 4'd10;
                state_d = EMIT;
            end
        end else if (out_ready) begin
            if (round_q == 4'd0) begin
                state_d = IDLE;
            end else begin
                key_d = {p0, p1, p2, p3};
                round_d = round_q - 4'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q <= '0;
            round_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            round_q <= round_d;
            rdy_q <= state_d == IDLE;
        end
    end
    assign in_ready = rdy_q;
    assign out_valid = state_q == EMIT;
    assign busy = state_q == EMIT;
    assign out_key = key_q;
    assign out_round = round_q;
    assign out_last = state_q == EMIT && round_q == 4'd0;
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: vector table plus random round trips against a forward key-expansion model.
module tb_inv_key_schedule;
    logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [127:0] key_in, out_key;
    logic [3:0] out_round;
    int n_tests = 0, n_fail = 0;
    logic [7:0] sb [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];
    typedef struct {
        logic [127:0] key_in, r0, r9, r1;
        bit has_mid;
    } vec_t;
    vec_t tbl [2];

    inv_key_schedule dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
        .out_round(out_round), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // S-box from the generator-3 log walk: p steps by *3, q by /3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic stream(input logic [127:0] k, input logic [127:0] ck, input int pct,
                          input bit intrude, input int abort_at);
        int t;
        expand(ck);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_load", in_ready, 1);
        in_valid = 1;
        key_in = k;
        out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        for (int r = 10; r >= 0; r--) begin
            int st;
            logic hs;
            st = 0;
            do begin
                chk($sformatf("out_valid_r%0d", r), out_valid, 1);
                chk($sformatf("busy_r%0d", r), busy, 1);
                chk($sformatf("out_key_r%0d", r), out_key, exp_rk[r]);
                chk($sformatf("out_round_r%0d", r), out_round, r);
                chk($sformatf("out_last_r%0d", r), out_last, r == 0);
                got_rk[r] = out_key;
                hs = ($urandom_range(99) < pct) || st > 16;
                st++;
                out_ready = hs;
                if (intrude) begin
                    in_valid = $urandom_range(1);
                    key_in = ~k;
                end
                @(negedge clk);
            end while (!hs);
            if (r == abort_at) begin
                rst = 1;
                out_ready = 0;
                in_valid = 0;
                @(negedge clk);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_out_key", out_key, 0);
                chk("abort_out_round", out_round, 0);
                chk("abort_out_last", out_last, 0);
                chk("abort_in_ready", in_ready, 0);
                rst = 0;
                @(negedge clk);
                chk("abort_in_ready_after", in_ready, 1);
                chk("abort_out_valid_after", out_valid, 0);
                return;
            end
        end
        out_ready = 0;
        in_valid = 0;
        chk("done_in_ready", in_ready, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        logic [127:0] ck;
        tbl[0] = '{FIPS_R10, FIPS_R0, 128'hac7766f319fadc2128d12941575c006e,
                   128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
        tbl[1] = '{128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h0, 128'h0, 128'h0, 1'b0};
        build_sbox();
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        key_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_key", out_key, 0);
        chk("rst_out_round", out_round, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 2; i++) begin
            stream(tbl[i].key_in, tbl[i].r0, 100, 0, -1);
            chk($sformatf("vec%0d_r10", i), got_rk[10], tbl[i].key_in);
            chk($sformatf("vec%0d_r0", i), got_rk[0], tbl[i].r0);
            if (tbl[i].has_mid) begin
                chk($sformatf("vec%0d_r9", i), got_rk[9], tbl[i].r9);
                chk($sformatf("vec%0d_r1", i), got_rk[1], tbl[i].r1);
            end
        end
        stream(FIPS_R10, FIPS_R0, 50, 0, -1);
        chk("bp_r0", got_rk[0], FIPS_R0);
        stream(FIPS_R10, FIPS_R0, 60, 1, -1);
        chk("intrude_r0", got_rk[0], FIPS_R0);
        stream(tbl[1].key_in, 128'h0, 100, 0, -1);
        chk("after_intrude_r0", got_rk[0], 128'h0);
        stream(FIPS_R10, FIPS_R0, 100, 0, 6);
        stream(FIPS_R10, FIPS_R0, 100, 0, -1);
        chk("after_abort_r0", got_rk[0], FIPS_R0);
        for (int n = 0; n < 100; n++) begin
            ck = {$urandom, $urandom, $urandom, $urandom};
            expand(ck);
            stream(exp_rk[10], ck, 70, 0, -1);
            chk($sformatf("rt%0d_r0", n), got_rk[0], ck);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
